// File: rtl/mc_sched_pkg.sv
// Shared definitions for the bank read/write mode scheduler: mode
// encodings, the controller state enum and counter-width helpers.
package mc_sched_pkg;

    // Value of the mode output while each direction is being drained
    localparam logic MODE_READ  = 1'b1;
    localparam logic MODE_WRITE = 1'b0;

    // Controller states; the PENDING states wait for a burst boundary
    typedef enum logic [1:0] {
        READ_MODE  = 2'd0,
        WR_PENDING = 2'd1,
        WRITE_MODE = 2'd2,
        RD_PENDING = 2'd3
    } mc_state_e;

    // Bits needed to hold any value 0..max_val (at least one bit)
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rw_mode_ctrl_if.sv
// Bus between the bank scheduler and the read/write mode controller.
interface rw_mode_ctrl_if
    import mc_sched_pkg::*;
#(
    parameter int ARR_NUM_RD = 4,
    parameter int ARR_NUM_WR = 3,
    parameter int CNT_W      = 4
);
    // Handshake semantics: wr_push/wr_pop are single-cycle event strobes
    // with no backpressure (each high cycle is exactly one event);
    // rd_empty and sched_idle are level signals sampled every rising edge;
    // all controller outputs are registered and valid every cycle.
    logic [ARR_NUM_WR-1:0] wr_push;
    logic [ARR_NUM_WR-1:0] wr_pop;
    logic [ARR_NUM_RD-1:0] rd_empty;
    logic                  sched_idle;
    logic                  mode;
    logic                  drain_active;
    logic [CNT_W-1:0]      wr_count;
    logic                  starve_flag;
    logic                  switch_pulse;
    mc_state_e             state_dbg;

    modport master (
        output wr_push, wr_pop, rd_empty, sched_idle,
        input  mode, drain_active, wr_count, starve_flag, switch_pulse, state_dbg
    );

    modport slave (
        input  wr_push, wr_pop, rd_empty, sched_idle,
        output mode, drain_active, wr_count, starve_flag, switch_pulse, state_dbg
    );

endinterface

// File: rtl/wr_occupancy_cnt.sv
// Tracks the total number of entries held across all write FIFOs of a bank.
module wr_occupancy_cnt
    import mc_sched_pkg::*;
#(
    parameter int ARR_NUM_WR = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 4
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ARR_NUM_WR-1:0] i_push,
    input  logic [ARR_NUM_WR-1:0] i_pop,
    output logic [CNT_W-1:0]      o_count
);
    localparam int MAX_CNT = ARR_NUM_WR * FIFO_DEPTH;

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_next;
    int               w_push_n;
    int               w_pop_n;
    int               w_sum;

    // Net change this cycle; a push and pop on one FIFO cancel naturally
    always_comb begin
        w_push_n = 0;
        w_pop_n  = 0;
        for (int i = 0; i < ARR_NUM_WR; i++) begin
            w_push_n = w_push_n + int'(i_push[i]);
            w_pop_n  = w_pop_n + int'(i_pop[i]);
        end
        w_sum = int'(r_count) + w_push_n - w_pop_n;
        if (w_sum < 0) begin
            w_next = '0;
        end else if (w_sum > MAX_CNT) begin
            w_next = CNT_W'(MAX_CNT);
        end else begin
            w_next = CNT_W'(w_sum);
        end
    end

    // Occupancy register, clamped to the physical capacity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;

    // Popping an empty bank or pushing a full one is an upstream bug
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) w_sum >= 0);
    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) w_sum <= MAX_CNT);

endmodule

// File: rtl/rw_mode_ctrl.sv
// Read/write drain mode controller for one bank: decides when the scheduler
// should switch between draining reads and draining writes, with hysteresis
// (watermarks + minimum dwell) and a read-starvation escape.
module rw_mode_ctrl
    import mc_sched_pkg::*;
#(
    parameter int ARR_NUM_RD    = 4,
    parameter int ARR_NUM_WR    = 3,
    parameter int FIFO_DEPTH    = 4,
    parameter int WR_HIGH       = 8,
    parameter int WR_LOW        = 2,
    parameter int MIN_DWELL     = 8,
    parameter int RD_STARVE_MAX = 64
)(
    input  logic          clk,
    input  logic          rst_n,
    rw_mode_ctrl_if.slave bus
);
    localparam int MAX_CNT  = ARR_NUM_WR * FIFO_DEPTH;
    localparam int CNT_W    = cnt_w(MAX_CNT);
    localparam int DWELL_W  = cnt_w(MIN_DWELL);
    localparam int STARVE_W = cnt_w(RD_STARVE_MAX);

    mc_state_e           r_state;
    mc_state_e           w_state_nxt;
    logic                r_mode;
    logic                w_mode_nxt;
    logic                r_drain_active;
    logic                r_switch_pulse;
    logic                r_starve_flag;
    logic [DWELL_W-1:0]  r_dwell;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic [STARVE_W-1:0] w_starve_nxt;
    logic [CNT_W-1:0]    w_wr_count;
    logic                w_rd_all_empty;
    logic                w_dwell_done;
    logic                w_wr_nonzero;
    logic                w_wr_high;
    logic                w_wr_low;
    logic                w_enter_mode;

    wr_occupancy_cnt #(
        .ARR_NUM_WR (ARR_NUM_WR),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_occ (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (bus.wr_push),
        .i_pop   (bus.wr_pop),
        .o_count (w_wr_count)
    );

    assign w_rd_all_empty = &bus.rd_empty;
    assign w_wr_nonzero   = (w_wr_count != '0);
    assign w_wr_high      = (int'(w_wr_count) >= WR_HIGH);
    assign w_wr_low       = (int'(w_wr_count) <= WR_LOW);
    assign w_dwell_done   = (int'(r_dwell) == MIN_DWELL);

    // Next-state decision; PENDING states only resolve at a burst boundary
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            READ_MODE: begin
                if (w_dwell_done && (w_wr_high || (w_rd_all_empty && w_wr_nonzero))) begin
                    w_state_nxt = WR_PENDING;
                end
            end
            WR_PENDING: begin
                // Nothing left to write: abandon the switch before it happens
                if (!w_wr_nonzero) begin
                    w_state_nxt = READ_MODE;
                end else if (bus.sched_idle) begin
                    w_state_nxt = WRITE_MODE;
                end
            end
            WRITE_MODE: begin
                // Starvation escape bypasses the minimum dwell
                if (r_starve_flag ||
                    (w_dwell_done && (!w_wr_nonzero || (w_wr_low && !w_rd_all_empty)))) begin
                    w_state_nxt = RD_PENDING;
                end
            end
            RD_PENDING: begin
                if (bus.sched_idle) begin
                    w_state_nxt = READ_MODE;
                end
            end
            default: w_state_nxt = READ_MODE;
        endcase
    end

    // Mode flips only when a PENDING state completes into the opposite mode
    always_comb begin
        w_mode_nxt   = r_mode;
        w_enter_mode = (w_state_nxt != r_state) &&
                       ((w_state_nxt == READ_MODE) || (w_state_nxt == WRITE_MODE));
        if ((r_state == WR_PENDING) && (w_state_nxt == WRITE_MODE)) begin
            w_mode_nxt = MODE_WRITE;
        end else if ((r_state == RD_PENDING) && (w_state_nxt == READ_MODE)) begin
            w_mode_nxt = MODE_READ;
        end
    end

    // Reads wait only while writes are being drained (or about to stop)
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if ((r_state == READ_MODE) || (r_state == WR_PENDING)) begin
            w_starve_nxt = '0;
        end else if (!w_rd_all_empty && (int'(r_starve_cnt) < RD_STARVE_MAX)) begin
            w_starve_nxt = r_starve_cnt + STARVE_W'(1);
        end
    end

    // State, mode and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= READ_MODE;
            r_mode         <= MODE_READ;
            r_drain_active <= 1'b0;
            r_switch_pulse <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_mode         <= w_mode_nxt;
            r_drain_active <= (w_state_nxt == WRITE_MODE);
            r_switch_pulse <= (w_mode_nxt != r_mode);
        end
    end

    // Dwell counter: restarts on entering a mode, saturates at MIN_DWELL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell <= '0;
        end else if (w_enter_mode) begin
            r_dwell <= '0;
        end else if (int'(r_dwell) < MIN_DWELL) begin
            r_dwell <= r_dwell + DWELL_W'(1);
        end
    end

    // Starvation counter and its saturation flag, updated together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt  <= '0;
            r_starve_flag <= 1'b0;
        end else begin
            r_starve_cnt  <= w_starve_nxt;
            r_starve_flag <= (int'(w_starve_nxt) == RD_STARVE_MAX);
        end
    end

    assign bus.mode         = r_mode;
    assign bus.drain_active = r_drain_active;
    assign bus.wr_count     = w_wr_count;
    assign bus.starve_flag  = r_starve_flag;
    assign bus.switch_pulse = r_switch_pulse;
    assign bus.state_dbg    = r_state;

endmodule

// File: tb/tb_rw_mode_ctrl.sv
// Bench for rw_mode_ctrl: directed scenarios plus randomized traffic,
// all checked every cycle against a mode/pending reference model.
module tb_rw_mode_ctrl;
    import mc_sched_pkg::*;

    localparam int ARR_NUM_RD    = 4;
    localparam int ARR_NUM_WR    = 3;
    localparam int FIFO_DEPTH    = 4;
    localparam int WR_HIGH       = 8;
    localparam int WR_LOW        = 2;
    localparam int MIN_DWELL     = 8;
    localparam int RD_STARVE_MAX = 64;
    localparam int MAX_CNT       = ARR_NUM_WR * FIFO_DEPTH;
    localparam int CNT_W         = cnt_w(MAX_CNT);

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    rw_mode_ctrl_if #(.ARR_NUM_RD(ARR_NUM_RD), .ARR_NUM_WR(ARR_NUM_WR), .CNT_W(CNT_W)) bus ();

    rw_mode_ctrl #(
        .ARR_NUM_RD    (ARR_NUM_RD),
        .ARR_NUM_WR    (ARR_NUM_WR),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .WR_HIGH       (WR_HIGH),
        .WR_LOW        (WR_LOW),
        .MIN_DWELL     (MIN_DWELL),
        .RD_STARVE_MAX (RD_STARVE_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Described as "which direction is draining" plus "a switch is pending",
    // with an unbounded time-in-mode counter.
    bit m_read, m_pend, m_flag, m_pulse;
    int m_cyc, m_occ, m_starve;
    bit n_read, n_pend, n_flag, n_pulse;
    int n_cyc, n_occ, n_starve;

    task automatic model_reset();
        m_read = 1; m_pend = 0; m_flag = 0; m_pulse = 0;
        m_cyc = 0; m_occ = 0; m_starve = 0;
    endtask

    task automatic model_next();
        bit all_empty;
        all_empty = (bus.rd_empty == '1);
        n_occ = m_occ + $countones(bus.wr_push) - $countones(bus.wr_pop);
        if (n_occ < 0) n_occ = 0;
        if (n_occ > MAX_CNT) n_occ = MAX_CNT;
        n_read = m_read; n_pend = m_pend; n_pulse = 0; n_cyc = m_cyc + 1;
        if (!m_pend) begin
            if (m_read) begin
                if (m_cyc >= MIN_DWELL && (m_occ >= WR_HIGH || (all_empty && m_occ > 0))) n_pend = 1;
            end else begin
                if (m_flag || (m_cyc >= MIN_DWELL && (m_occ == 0 || (m_occ <= WR_LOW && !all_empty))))
                    n_pend = 1;
            end
        end else if (m_read) begin
            if (m_occ == 0) begin
                n_pend = 0; n_cyc = 0;
            end else if (bus.sched_idle) begin
                n_pend = 0; n_read = 0; n_cyc = 0; n_pulse = 1;
            end
        end else if (bus.sched_idle) begin
            n_pend = 0; n_read = 1; n_cyc = 0; n_pulse = 1;
        end
        // reads can only starve while writes own the bank
        if (m_read) n_starve = 0;
        else if (!all_empty) n_starve = (m_starve + 1 > RD_STARVE_MAX) ? RD_STARVE_MAX : m_starve + 1;
        else n_starve = m_starve;
        n_flag = (n_starve == RD_STARVE_MAX);
    endtask

    function automatic mc_state_e model_state();
        if (m_read) return m_pend ? WR_PENDING : READ_MODE;
        return m_pend ? RD_PENDING : WRITE_MODE;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        m_read = n_read; m_pend = n_pend; m_flag = n_flag; m_pulse = n_pulse;
        m_cyc = n_cyc; m_occ = n_occ; m_starve = n_starve;
        chk("mode",   32'(bus.mode),         32'(m_read));
        chk("drain",  32'(bus.drain_active), 32'(!m_read && !m_pend));
        chk("count",  32'(bus.wr_count),     32'(m_occ));
        chk("starve", 32'(bus.starve_flag),  32'(m_flag));
        chk("pulse",  32'(bus.switch_pulse), 32'(m_pulse));
        chk("state",  32'(bus.state_dbg),    32'(model_state()));
    endtask

    task automatic drive(input logic [2:0] push, input logic [2:0] pop,
                         input logic [3:0] empty, input logic idle);
        bus.wr_push = push; bus.wr_pop = pop; bus.rd_empty = empty; bus.sched_idle = idle;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        bus.wr_push = '0; bus.wr_pop = '0;
        #2;
        chk("rst_mode",   32'(bus.mode),         32'd1);
        chk("rst_drain",  32'(bus.drain_active), 32'd0);
        chk("rst_count",  32'(bus.wr_count),     32'd0);
        chk("rst_starve", 32'(bus.starve_flag),  32'd0);
        chk("rst_pulse",  32'(bus.switch_pulse), 32'd0);
        chk("rst_state",  32'(bus.state_dbg),    32'(READ_MODE));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int first;
        int bad;
        logic [2:0] push, pop;
        n_checks = 0; n_fail = 0;
        rst_n = 1'b1;
        drive(3'b000, 3'b000, 4'b1111, 1'b1);
        model_reset();
        #1;
        do_reset();

        // 8 writes, all reads empty: WR_PENDING after dwell, then switch
        for (int i = 0; i < 8; i++) begin
            drive(3'b001, 3'b000, 4'b1111, 1'b1);
            step();
        end
        drive(3'b000, 3'b000, 4'b1111, 1'b1);
        step();
        chk("s1_pending", 32'(bus.state_dbg), 32'(WR_PENDING));
        step();
        chk("s1_mode",  32'(bus.mode),         32'd0);
        chk("s1_pulse", 32'(bus.switch_pulse), 32'd1);
        chk("s1_count", 32'(bus.wr_count),     32'd8);

        // drain to low watermark with reads waiting, scheduler busy
        for (int i = 0; i < 3; i++) begin
            drive(3'b000, 3'b011, 4'b1110, 1'b0);
            step();
        end
        drive(3'b000, 3'b000, 4'b1110, 1'b0);
        for (int i = 0; i < 20 && !(m_pend && !m_read); i++) step();
        chk("s2_rd_pending", 32'(bus.state_dbg), 32'(RD_PENDING));
        for (int i = 0; i < 5; i++) begin
            step();
            chk("s2_hold_mode", 32'(bus.mode), 32'd0);
        end
        drive(3'b000, 3'b000, 4'b1110, 1'b1);
        step();
        chk("s2_mode",  32'(bus.mode),         32'd1);
        chk("s2_pulse", 32'(bus.switch_pulse), 32'd1);

        // fill to 10, enter WRITE_MODE, then starve the reads
        drive(3'b111, 3'b000, 4'b0111, 1'b1); step();
        drive(3'b111, 3'b000, 4'b0111, 1'b1); step();
        drive(3'b011, 3'b000, 4'b0111, 1'b1); step();
        drive(3'b000, 3'b000, 4'b0111, 1'b1);
        for (int i = 0; i < 40 && !(!m_read && !m_pend); i++) step();
        chk("s3_enter_write", 32'(bus.drain_active), 32'd1);
        chk("s3_count",       32'(bus.wr_count),     32'd10);
        drive(3'b000, 3'b000, 4'b0111, 1'b0);
        first = 0;
        for (int i = 1; i <= 70; i++) begin
            step();
            if (first == 0 && bus.starve_flag) first = i;
        end
        chk("s3_starve_cycles", 32'(first),    32'd64);
        chk("s3_busy_mode",     32'(bus.mode), 32'd0);
        drive(3'b000, 3'b000, 4'b0111, 1'b1);
        step();
        chk("s3_mode", 32'(bus.mode), 32'd1);

        // same-cycle push and pop on FIFO 1 at count 5
        drive(3'b000, 3'b111, 4'b0111, 1'b1); step();
        drive(3'b000, 3'b011, 4'b0111, 1'b1); step();
        chk("s4_count_pre", 32'(bus.wr_count), 32'd5);
        drive(3'b010, 3'b010, 4'b0111, 1'b1); step();
        chk("s4_count", 32'(bus.wr_count), 32'd5);

        // reset while a write switch is pending
        drive(3'b000, 3'b000, 4'b1111, 1'b0);
        for (int i = 0; i < 20 && !(m_read && m_pend); i++) step();
        chk("s5_pending", 32'(bus.state_dbg), 32'(WR_PENDING));
        do_reset();
        drive(3'b000, 3'b000, 4'b1111, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("s5_mode",  32'(bus.mode),         32'd1);
            chk("s5_pulse", 32'(bus.switch_pulse), 32'd0);
        end

        // few writes while reads are busy: must stay in READ_MODE
        drive(3'b111, 3'b000, 4'b0000, 1'b1);
        step();
        drive(3'b000, 3'b000, 4'b0000, 1'b1);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.mode !== 1'b1 || bus.state_dbg != READ_MODE) bad++;
        end
        chk("s6_no_switch", 32'(bad), 32'd0);

        // randomized traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            int delta;
            push = 3'($urandom_range(0, 7));
            pop  = 3'($urandom_range(0, 7));
            if ((i / 100) % 2 == 0) pop  = pop & 3'($urandom_range(0, 7));
            else                    push = push & 3'($urandom_range(0, 7));
            delta = $countones(push) - $countones(pop);
            if (m_occ + delta > MAX_CNT) push = 3'b000;
            delta = $countones(push) - $countones(pop);
            if (m_occ + delta < 0) pop = 3'b000;
            bus.wr_push    = push;
            bus.wr_pop     = pop;
            bus.rd_empty   = ($urandom_range(0, 9) < 4) ? 4'b1111 : 4'($urandom_range(0, 15));
            bus.sched_idle = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 399) == 0) do_reset();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rw_mode_ctrl.md
RW_MODE_CTRL -- requirements
Module: rw_mode_ctrl

Interface
REQ-001 SHALL have parameter ARR_NUM_RD, default 4, number of read FIFOs per bank.
REQ-002 SHALL have parameter ARR_NUM_WR, default 3, number of write FIFOs per bank.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries per write FIFO.
REQ-004 SHALL have parameter WR_HIGH, default 8, write-occupancy high watermark.
REQ-005 SHALL have parameter WR_LOW, default 2, write-occupancy low watermark.
REQ-006 SHALL have parameter MIN_DWELL, default 8, minimum cycles in a mode before requesting a switch.
REQ-007 SHALL have parameter RD_STARVE_MAX, default 64, read-starvation limit in cycles.
REQ-008 clk  in  1  single clock, all flops on rising edge.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 wr_push  in  ARR_NUM_WR  per-write-FIFO push strobe, this cycle.
REQ-011 wr_pop  in  ARR_NUM_WR  per-write-FIFO pop strobe, this cycle.
REQ-012 rd_empty  in  ARR_NUM_RD  read FIFO empty flags.
REQ-013 sched_idle  in  1  bank scheduler is at a burst boundary (EMPTY/FINISH).
REQ-014 mode  out  1  1 = READ draining, 0 = WRITE draining, registered.
REQ-015 drain_active  out  1  high while in WRITE_MODE, registered.
REQ-016 wr_count  out  $clog2(ARR_NUM_WR*FIFO_DEPTH+1)  total write entries held, registered.
REQ-017 starve_flag  out  1  starvation counter at RD_STARVE_MAX, registered.
REQ-018 switch_pulse  out  1  one-cycle pulse in the cycle mode changes.

Function
REQ-019 wr_count SHALL update each cycle by popcount(wr_push) minus popcount(wr_pop); simultaneous push and pop on the same FIFO net to zero.
REQ-020 wr_count SHALL clamp at 0 and at ARR_NUM_WR*FIFO_DEPTH; underflow/overflow attempts are illegal and SHALL be flagged by assertion.
REQ-021 FSM states SHALL be READ_MODE, WR_PENDING, WRITE_MODE, RD_PENDING.
REQ-022 Dwell counter SHALL clear on entry to READ_MODE or WRITE_MODE, increment each cycle, and saturate at MIN_DWELL.
REQ-023 READ_MODE to WR_PENDING SHALL occur when dwell = MIN_DWELL and either (wr_count >= WR_HIGH) or (&rd_empty and wr_count > 0).
REQ-024 WR_PENDING to WRITE_MODE SHALL occur on the first cycle with sched_idle = 1; WR_PENDING to READ_MODE SHALL occur if wr_count = 0, and this takes priority over the transition to WRITE_MODE.
REQ-025 WRITE_MODE to RD_PENDING SHALL occur when dwell = MIN_DWELL and any of: wr_count = 0; (wr_count <= WR_LOW and ~&rd_empty); starve_flag = 1.
REQ-026 The starve_flag exit in REQ-025 SHALL ignore the dwell condition.
REQ-027 RD_PENDING to READ_MODE SHALL occur on the first cycle with sched_idle = 1.
REQ-028 mode SHALL change only on a PENDING-to-MODE transition, so mode never toggles while sched_idle = 0.
REQ-029 switch_pulse SHALL assert in the same cycle that the new mode value appears.
REQ-030 Starvation counter SHALL clear in READ_MODE and WR_PENDING.
REQ-031 In WRITE_MODE and RD_PENDING, the starvation counter SHALL increment when ~&rd_empty, hold otherwise, and saturate at RD_STARVE_MAX.
REQ-032 Latency: a transition condition true at edge N SHALL give a state change at edge N+1; mode SHALL be updated at the edge that enters READ_MODE or WRITE_MODE.

Reset
REQ-033 On rst_n low, immediately and independent of clk: state READ_MODE, mode = 1, drain_active = 0, wr_count = 0, starve_flag = 0, switch_pulse = 0, dwell and starvation counters 0.
REQ-034 Reset asserted mid-PENDING SHALL abandon the pending switch; no switch_pulse SHALL follow deassertion.

Structure
REQ-035 READ/WRITE encodings, the state enum and count-width helpers SHALL live in shared package mc_sched_pkg.
REQ-036 Occupancy tracking (REQ-019/020) SHALL be sub-module wr_occupancy_cnt; the FSM and dwell/starvation counters SHALL stay in rw_mode_ctrl.

Verification
REQ-037 Reset, then push 8 writes over 8 cycles, rd_empty = 4'b1111, sched_idle = 1 -> WR_PENDING after dwell 8, mode = 0 and switch_pulse at the next edge, wr_count = 8.
REQ-038 In WRITE_MODE, wr_count = 8, pop down to 2 with rd_empty = 4'b1110, sched_idle = 0 for 5 cycles -> RD_PENDING holds mode = 0 for 5 cycles, then mode = 1 one edge after sched_idle rises.
REQ-039 In WRITE_MODE, wr_count held at 10, rd_empty = 4'b0111 -> starve_flag after 64 cycles, mode = 1 at the next idle boundary.
REQ-040 Same-cycle push and pop on FIFO 1 with wr_count = 5 -> wr_count stays 5.
REQ-041 rst_n pulsed low while in WR_PENDING -> all outputs at reset values at once, mode stays 1 afterward.
REQ-042 In READ_MODE, wr_count = 3, rd_empty = 4'b0000 -> no switch for 200 cycles.
